// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment digit scanner.
package seg_pkg;

    localparam int DIG_POL_ACTIVE_HIGH = 0;
    localparam int DIG_POL_ACTIVE_LOW  = 1;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit counter; publishes the current index plus look-ahead strobes
// so the scanner can register its outputs aligned with the counter.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int  NUM_DIGITS = 4,
    parameter int  SCAN_DIV   = 1000,
    parameter int  BLANK_CYC  = 16,
    localparam int CNT_W      = clog2(SCAN_DIV),
    localparam int IDX_W      = clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] digit_idx,
    output logic [IDX_W-1:0] idx_next,
    output logic             slot_wrap,
    output logic             in_blank,
    output logic             frame_end,
    output logic             frame_end_next
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // in_blank and frame_end_next describe the cycle after the coming edge
    assign digit_idx      = idx_q;
    assign idx_next       = idx_d;
    assign slot_wrap      = (cnt_q == CNT_LAST);
    assign in_blank       = (cnt_d < CNT_BLANK);
    assign frame_end      = slot_wrap && (idx_q == IDX_LAST);
    assign frame_end_next = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexes a hex value onto one nibble bus with frame-synchronous double buffering.
//   state    | meaning
//   ST_BLANK | leading part of a slot, all digits off, nibble settling
//   ST_DRIVE | selected digit enabled (unless leading-zero blanked)
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int  NUM_DIGITS     = 4,
    parameter int  SCAN_DIV       = 1000,
    parameter int  BLANK_CYC      = 16,
    parameter int  DIG_ACTIVE_LOW = 1,
    localparam int IDX_W          = clog2(NUM_DIGITS),
    localparam int VAL_W          = 4 * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  lz_blank_en,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW == DIG_POL_ACTIVE_LOW) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [IDX_W-1:0] idx_next;
    logic             slot_wrap, in_blank, frame_end, frame_end_next;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .digit_idx      (digit_idx),
        .idx_next       (idx_next),
        .slot_wrap      (slot_wrap),
        .in_blank       (in_blank),
        .frame_end      (frame_end),
        .frame_end_next (frame_end_next)
    );

    scan_state_t           state_q, state_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic                  pend_q, pend_d;
    nibble_t               nib_q, nib_d;
    logic                  dp_q, dp_d;
    logic                  blank_q, blank_d;
    logic                  frame_done_q, frame_done_d;
    logic [VAL_W-1:0]      upper;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_d       = pend_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        nib_d        = nib_q;
        blank_d      = blank_q;
        state_d      = state_q;
        frame_done_d = frame_end_next;

        // a load landing on the frame-end cycle skips the pending stage
        if (frame_end) begin
            pend_d = 1'b0;
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_mask;
            end else if (pend_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pend_d     = 1'b1;
        end

        // digits idx_next and above, shifted down; all-zero means a leading zero
        upper = disp_val_d >> {idx_next, 2'b00};
        if (slot_wrap) begin
            nib_d   = upper[3:0];
            blank_d = lz_blank_en && (idx_next != '0) && (upper == '0);
        end

        if (state_q == ST_BLANK && !in_blank) begin
            state_d = ST_DRIVE;
        end else if (state_q == ST_DRIVE && slot_wrap) begin
            state_d = ST_BLANK;
        end

        onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
        dig_en_d = DIG_OFF;
        dp_d     = 1'b0;
        if (state_d == ST_DRIVE && !blank_q) begin
            dig_en_d = DIG_OFF ^ onehot;
            dp_d     = disp_dp_q[digit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            nib_q        <= '0;
            blank_q      <= 1'b0;
            dig_en_q     <= DIG_OFF;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            nib_q        <= nib_d;
            blank_q      <= blank_d;
            dig_en_q     <= dig_en_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign a          = nib_q[3];
    assign b          = nib_q[2];
    assign c          = nib_q[1];
    assign d          = nib_q[0];
    assign dp_out     = dp_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: cycle model from absolute time, directed vectors, random loads.
module tb_seg_digit_scanner;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_blank_en = 1'b0;
    logic        a, b, c, d, dp_out, frame_done;
    logic [3:0]  dig_en;
    logic [1:0]  digit_idx;

    always #5 clk = ~clk;

    seg_digit_scanner #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .BLANK_CYC      (BC),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .lz_blank_en (lz_blank_en),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .dp_out      (dp_out),
        .dig_en      (dig_en),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    int total = 0;
    int bad   = 0;

    // reference state: t counts cycles since reset release
    int          t;
    logic [15:0] m_disp, m_pval;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pend, m_lz;
    logic        cur_lz;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_disp = '0;
        m_pval = '0;
        m_dp   = '0;
        m_pdp  = '0;
        m_pend = 1'b0;
        m_lz   = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] dpm,
                              input logic lz);
        int cnt, idx;
        cnt = t % SD;
        idx = (t / SD) % ND;
        if (cnt == SD - 1 && idx == ND - 1) begin
            if (ld) begin
                m_disp = v;
                m_dp   = dpm;
            end else if (m_pend) begin
                m_disp = m_pval;
                m_dp   = m_pdp;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pval = v;
            m_pdp  = dpm;
            m_pend = 1'b1;
        end
        if (cnt == SD - 1) m_lz = lz;
        t++;
    endtask

    task automatic check_model();
        int         cnt, idx;
        logic       drive, blanked;
        logic [3:0] one, exp_en;
        logic       exp_dp;
        logic [3:0] exp_nib;
        cnt     = t % SD;
        idx     = (t / SD) % ND;
        drive   = (cnt >= BC);
        blanked = m_lz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
        one     = 4'b0001 << idx;
        exp_en  = (drive && !blanked) ? ~one : 4'hF;
        exp_dp  = drive && !blanked && m_dp[idx];
        exp_nib = m_disp[4*idx +: 4];
        cmp("digit_idx", 32'(digit_idx), 32'(idx));
        cmp("dig_en", 32'(dig_en), 32'(exp_en));
        cmp("nibble", 32'({a, b, c, d}), 32'(exp_nib));
        cmp("dp_out", 32'(dp_out), 32'(exp_dp));
        cmp("frame_done", 32'(frame_done), 32'(cnt == SD - 1 && idx == ND - 1));
    endtask

    task automatic run_cycle(input logic ld, input logic [15:0] v, input logic [3:0] dpm,
                             input logic lz);
        load        = ld;
        value       = v;
        dp_mask     = dpm;
        lz_blank_en = lz;
        @(posedge clk);
        model_edge(ld, v, dpm, lz);
        #1;
        check_model();
    endtask

    task automatic idle_until(input int frame_pos);
        for (int n = 0; n < 2 * FR && (t % FR) != frame_pos; n++) run_cycle(1'b0, 16'h0, 4'h0, cur_lz);
        cmp("reach_pos", 32'(t % FR), 32'(frame_pos));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        cmp({tag, "_dig_en"}, 32'(dig_en), 32'hF);
        cmp({tag, "_nibble"}, 32'({a, b, c, d}), 32'h0);
        cmp({tag, "_dp"}, 32'(dp_out), 32'h0);
        cmp({tag, "_fdone"}, 32'(frame_done), 32'h0);
        cmp({tag, "_idx"}, 32'(digit_idx), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_model();
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpm;
        logic        lz;
        int          k;
        logic [3:0]  nib;
        logic [3:0]  en;
        logic        dp;
    } vec_t;

    vec_t vt[13];

    initial begin
        int          seen_one, seen_two, dp_hits, dp_out_slot;
        logic [31:0] r;
        logic [15:0] rv;
        logic        rl;

        vt[0]  = '{16'h1234, 4'b0000, 1'b0,  2, 4'b0100, 4'b1110, 1'b0};
        vt[1]  = '{16'h1234, 4'b0000, 1'b0, 26, 4'b0001, 4'b0111, 1'b0};
        vt[2]  = '{16'h0050, 4'b0000, 1'b1, 26, 4'b0000, 4'b1111, 1'b0};
        vt[3]  = '{16'h0050, 4'b0000, 1'b1, 18, 4'b0000, 4'b1111, 1'b0};
        vt[4]  = '{16'h0050, 4'b0000, 1'b1, 10, 4'b0101, 4'b1101, 1'b0};
        vt[5]  = '{16'h0050, 4'b0000, 1'b1,  2, 4'b0000, 4'b1110, 1'b0};
        vt[6]  = '{16'h0000, 4'b0000, 1'b1, 10, 4'b0000, 4'b1111, 1'b0};
        vt[7]  = '{16'h0000, 4'b0000, 1'b1,  4, 4'b0000, 4'b1110, 1'b0};
        vt[8]  = '{16'hABCD, 4'b0010, 1'b0, 10, 4'b1100, 4'b1101, 1'b1};
        vt[9]  = '{16'hABCD, 4'b0010, 1'b0,  9, 4'b1100, 4'b1111, 1'b0};
        vt[10] = '{16'hABCD, 4'b0010, 1'b0,  2, 4'b1101, 4'b1110, 1'b0};
        vt[11] = '{16'h0300, 4'b1111, 1'b1, 26, 4'b0000, 4'b1111, 1'b0};
        vt[12] = '{16'h0300, 4'b1111, 1'b1, 18, 4'b0011, 4'b1011, 1'b1};

        cur_lz = 1'b0;
        model_reset();
        #2;
        do_reset("rst");

        // load mid-frame: frame 0 stays blank-valued, frame 1 shows the new digits
        idle_until(5);
        run_cycle(1'b1, 16'h1234, 4'h0, 1'b0);
        idle_until(FR - 1);
        cmp("frame_done_31", 32'(frame_done), 32'h1);
        idle_until(2);
        cmp("f1_slot0_nib", 32'({a, b, c, d}), 32'h4);
        cmp("f1_slot0_en", 32'(dig_en), 32'hE);
        idle_until(26);
        cmp("f1_slot3_nib", 32'({a, b, c, d}), 32'h1);
        cmp("f1_slot3_en", 32'(dig_en), 32'h7);

        // two loads in one frame: the last one wins, the first never shows
        idle_until(3);
        run_cycle(1'b1, 16'h1111, 4'h0, 1'b0);
        idle_until(20);
        run_cycle(1'b1, 16'h2222, 4'h0, 1'b0);
        idle_until(0);
        seen_one = 0;
        seen_two = 0;
        for (int n = 0; n < FR; n++) begin
            if (dig_en != 4'hF && {a, b, c, d} == 4'h1) seen_one++;
            if (dig_en != 4'hF && {a, b, c, d} == 4'h2) seen_two++;
            run_cycle(1'b0, 16'h0, 4'h0, 1'b0);
        end
        cmp("no_tear_ones", 32'(seen_one), 32'h0);
        cmp("last_wins_twos", 32'(seen_two), 32'(ND * (SD - BC)));

        // load on the frame-end cycle goes straight to the display
        idle_until(FR - 1);
        run_cycle(1'b1, 16'hABCD, 4'b0010, 1'b0);
        cmp("bypass_nib", 32'({a, b, c, d}), 32'hD);
        dp_hits     = 0;
        dp_out_slot = 0;
        for (int n = 0; n < FR; n++) begin
            if (dp_out) begin
                dp_hits++;
                if ((t % FR) / SD != 1 || (t % SD) < BC) dp_out_slot++;
            end
            run_cycle(1'b0, 16'h0, 4'h0, 1'b0);
        end
        cmp("dp_hits", 32'(dp_hits), 32'(SD - BC));
        cmp("dp_wrong_slot", 32'(dp_out_slot), 32'h0);

        // asynchronous reset while slot 2 is driving
        idle_until(2 * SD + 4);
        cmp("pre_rst_en", 32'(dig_en), 32'hB);
        #2;
        do_reset("rst_async");
        cmp("post_rst_nib", 32'({a, b, c, d}), 32'h0);

        for (int i = 0; i < 13; i++) begin
            cur_lz = vt[i].lz;
            run_cycle(1'b1, vt[i].val, vt[i].dpm, cur_lz);
            idle_until(0);
            idle_until(vt[i].k);
            cmp($sformatf("vec%0d_nib", i), 32'({a, b, c, d}), 32'(vt[i].nib));
            cmp($sformatf("vec%0d_en", i), 32'(dig_en), 32'(vt[i].en));
            cmp($sformatf("vec%0d_dp", i), 32'(dp_out), 32'(vt[i].dp));
        end

        for (int n = 0; n < 1200; n++) begin
            r  = $urandom;
            rv = r[15:0] >> (4 * $urandom_range(0, 4));
            rl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) cur_lz = ~cur_lz;
            run_cycle(rl, rv, 4'($urandom_range(0, 15)), cur_lz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
